// File: rtl/hm01b0_mcu_reader_if.sv
// rtl/hm01b0_mcu_reader_if.sv - MCU sample stream from the stripe reader to the DCT stage
// Beat 0 of each MCU carries start_of_mcu, beat 63 end_of_mcu, the last stripe beat end_of_stripe.
interface hm01b0_mcu_reader_if;
  logic [7:0] out_pixval;
  logic       out_valid;
  logic       out_ready;
  logic       out_start_of_mcu;
  logic       out_end_of_mcu;
  logic       out_end_of_stripe;

  modport master (
    output out_pixval,
    output out_valid,
    output out_start_of_mcu,
    output out_end_of_mcu,
    output out_end_of_stripe,
    input  out_ready
  );

  modport slave (
    input  out_pixval,
    input  out_valid,
    input  out_start_of_mcu,
    input  out_end_of_mcu,
    input  out_end_of_stripe,
    output out_ready
  );
endinterface

// File: rtl/hm01b0_mcu_reader.sv
// rtl/hm01b0_mcu_reader.sv - streams finished 8-row stripes out of the EBR bank as 8x8 MCUs
// Reads run ahead of the consumer through the 1-cycle EBR and a 2-entry skid buffer.
module hm01b0_mcu_reader #(
  parameter int width_pix = 320,
  parameter int num_ebr   = 5,
  parameter int ebr_size  = 512
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        frontbuffer_select,
  output logic                        read_buffer_select,
  output logic [$clog2(num_ebr)-1:0]  read_block_select,
  output logic [$clog2(ebr_size)-1:0] read_addr,
  output logic                        rden,
  input  logic [7:0]                  read_data,
  hm01b0_mcu_reader_if.master         mcu_out,
  output logic                        busy,
  output logic                        overrun
);
  localparam int blk_w  = $clog2(num_ebr);
  localparam int addr_w = $clog2(ebr_size);
  localparam int grp_w  = addr_w - 6;
  localparam int groups = (width_pix / 8) / num_ebr;
  localparam logic [blk_w-1:0] last_blk = blk_w'(num_ebr - 1);
  localparam logic [grp_w-1:0] last_grp = grp_w'(groups - 1);

  typedef enum logic [1:0] {st_idle, st_read, st_drain} state_t;

  state_t           state;
  logic             fb_q;
  logic [2:0]       px;
  logic [2:0]       py;
  logic [blk_w-1:0] blk;
  logic [grp_w-1:0] grp;
  logic             pend_valid;
  logic [2:0]       pend_flags;
  logic [10:0]      skid0;
  logic [10:0]      skid1;
  logic [1:0]       skid_cnt;

  logic        toggle;
  logic        pop;
  logic        last_read;
  logic        last_pop;
  logic        start_now;
  logic [2:0]  rd_flags;
  logic [2:0]  occ_after;
  logic [10:0] push_word;

  assign toggle    = frontbuffer_select != fb_q;
  assign pop       = mcu_out.out_valid && mcu_out.out_ready;
  assign last_read = (px == 3'd7) && (py == 3'd7) && (blk == last_blk) && (grp == last_grp);
  assign last_pop  = pop && skid0[0];
  assign start_now = toggle && ((state == st_idle) || ((state == st_drain) && last_pop));
  assign rd_flags  = {(px == 3'd0) && (py == 3'd0), (px == 3'd7) && (py == 3'd7), last_read};
  assign push_word = {read_data, pend_flags};

  // A new read lands two edges later; issue it only if the buffer can hold it with no further pops.
  assign occ_after = 3'(skid_cnt) + 3'(pend_valid) - 3'(pop);
  assign rden      = (state == st_read) && (occ_after < 3'd2);

  assign read_block_select = blk;
  assign read_addr         = {grp, py, px};

  assign mcu_out.out_valid         = skid_cnt != 2'd0;
  assign mcu_out.out_pixval        = skid0[10:3];
  assign mcu_out.out_start_of_mcu  = mcu_out.out_valid && skid0[2];
  assign mcu_out.out_end_of_mcu    = mcu_out.out_valid && skid0[1];
  assign mcu_out.out_end_of_stripe = mcu_out.out_valid && skid0[0];

  always_ff @(posedge clock) begin
    if (reset) begin
      state              <= st_idle;
      fb_q               <= frontbuffer_select;
      read_buffer_select <= 1'b0;
      busy               <= 1'b0;
      overrun            <= 1'b0;
      px                 <= '0;
      py                 <= '0;
      blk                <= '0;
      grp                <= '0;
      pend_valid         <= 1'b0;
      pend_flags         <= '0;
      skid0              <= '0;
      skid1              <= '0;
      skid_cnt           <= '0;
    end else begin
      fb_q       <= frontbuffer_select;
      pend_valid <= rden;
      pend_flags <= rd_flags;

      // skid0 is always the head; a push lands behind whatever survives this cycle's pop.
      case ({pend_valid, pop})
        2'b10: begin
          if (skid_cnt == 2'd0) skid0 <= push_word;
          else                  skid1 <= push_word;
          skid_cnt <= skid_cnt + 2'd1;
        end
        2'b01: begin
          skid0    <= skid1;
          skid_cnt <= skid_cnt - 2'd1;
        end
        2'b11: begin
          if (skid_cnt == 2'd1) begin
            skid0 <= push_word;
          end else begin
            skid0 <= skid1;
            skid1 <= push_word;
          end
        end
        default: ;
      endcase

      if (rden) begin
        px <= px + 3'd1;
        if (px == 3'd7) begin
          py <= py + 3'd1;
          if (py == 3'd7) begin
            if (blk == last_blk) begin
              blk <= '0;
              grp <= (grp == last_grp) ? '0 : grp + grp_w'(1);
            end else begin
              blk <= blk + blk_w'(1);
            end
          end
        end
      end

      if (toggle && !start_now && (state != st_idle)) overrun <= 1'b1;

      if (start_now) begin
        state              <= st_read;
        busy               <= 1'b1;
        read_buffer_select <= ~frontbuffer_select;
        px                 <= '0;
        py                 <= '0;
        blk                <= '0;
        grp                <= '0;
      end else begin
        case (state)
          st_idle: ;
          st_read: begin
            if (rden && last_read) state <= st_drain;
          end
          st_drain: begin
            if (last_pop) begin
              state <= st_idle;
              busy  <= 1'b0;
            end
          end
          default: begin
            state <= st_idle;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_hm01b0_mcu_reader.sv
// tb/tb_hm01b0_mcu_reader.sv - directed stripe scenarios for hm01b0_mcu_reader
// A 1-cycle EBR model holds data = f(buf, block, addr); every beat is checked against f.
module tb_hm01b0_mcu_reader;
  localparam int beats = 2560;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       frontbuffer_select = 1'b0;
  logic       read_buffer_select;
  logic [2:0] read_block_select;
  logic [8:0] read_addr;
  logic       rden;
  logic [7:0] read_data = 8'h00;
  logic       busy;
  logic       overrun;

  hm01b0_mcu_reader_if mcu_if ();

  hm01b0_mcu_reader dut (
    .clock              (clock),
    .reset              (reset),
    .frontbuffer_select (frontbuffer_select),
    .read_buffer_select (read_buffer_select),
    .read_block_select  (read_block_select),
    .read_addr          (read_addr),
    .rden               (rden),
    .read_data          (read_data),
    .mcu_out            (mcu_if),
    .busy               (busy),
    .overrun            (overrun)
  );

  always #5 clock = ~clock;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   beat_idx = 0;
  int   reads_total = 0;
  int   xfers_total = 0;
  int   first_rden = -1;
  int   first_valid = -1;
  int   last_valid = -1;
  int   valid_cycles = 0;
  int   overrun_at = -1;
  int   ov_stage = 0;
  int   r0 = 0;
  int   v0 = 0;
  bit   ready_rand = 1'b0;
  bit   end_toggle = 1'b0;
  bit   restart_pending = 1'b0;
  bit   chk_busy = 1'b0;
  logic exp_buf = 1'b0;

  function automatic logic [7:0] ebr_val(logic bsel, int blk, int addr);
    int v;
    v = addr * 7 + blk * 29 + (addr / 256) * 83 + (bsel ? 151 : 0);
    return v[7:0];
  endfunction

  function automatic logic [10:0] exp_word(int b, logic bsel);
    int m, w, addr;
    m    = b / 64;
    w    = b % 64;
    addr = (m / 5) * 64 + w;
    return {ebr_val(bsel, m % 5, addr), w == 0, w == 63, b == beats - 1};
  endfunction

  always @(posedge clock)
    read_data <= rden ? ebr_val(read_buffer_select, int'(read_block_select), int'(read_addr)) : 8'hee;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d beat %0d)", tag, got, exp, cyc, beat_idx);
    end
  endtask

  task automatic tick();
    logic [10:0] got;
    int          occ;
    bit          xfer;
    @(negedge clock);
    mcu_if.out_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    if (overrun_at >= 0 && beat_idx == overrun_at) begin
      frontbuffer_select = ~frontbuffer_select;
      overrun_at = -1;
      ov_stage = 1;
    end
    if (end_toggle && mcu_if.out_valid && mcu_if.out_ready && beat_idx == beats - 1) begin
      frontbuffer_select = ~frontbuffer_select;
      end_toggle = 1'b0;
      restart_pending = 1'b1;
    end
    #1;
    cyc++;
    if (ov_stage == 2) begin
      check_eq("overrun_rise", overrun, 1);
      ov_stage = 0;
    end else if (ov_stage == 1) begin
      ov_stage = 2;
    end
    if (chk_busy) check_eq("busy_held", busy, 1);
    xfer = mcu_if.out_valid && mcu_if.out_ready;
    occ = reads_total + int'(rden) - xfers_total - int'(xfer);
    check_eq("occupancy_le2", occ <= 2, 1);
    if (rden) begin
      reads_total++;
      if (first_rden < 0) first_rden = cyc;
    end
    if (mcu_if.out_valid) begin
      valid_cycles++;
      if (first_valid < 0) first_valid = cyc;
      last_valid = cyc;
      got = {mcu_if.out_pixval, mcu_if.out_start_of_mcu, mcu_if.out_end_of_mcu, mcu_if.out_end_of_stripe};
      if (beat_idx < beats) check_eq("beat", got, exp_word(beat_idx, exp_buf));
      else                  check_eq("extra_beat", mcu_if.out_valid, 0);
    end
    if (xfer) begin
      xfers_total++;
      beat_idx++;
      if (restart_pending && beat_idx == beats) begin
        beat_idx = 0;
        exp_buf = ~frontbuffer_select;
        restart_pending = 1'b0;
      end
    end
  endtask

  task automatic run_beats(input int target, input int budget);
    int n;
    n = 0;
    while (beat_idx < target && n < budget) begin
      tick();
      n++;
    end
    if (beat_idx < target) check_eq("timeout", beat_idx, target);
  endtask

  initial begin
    mcu_if.out_ready = 1'b1;
    repeat (3) tick();
    check_eq("rst_valid", mcu_if.out_valid, 0);
    check_eq("rst_rden", rden, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_overrun", overrun, 0);
    check_eq("rst_rbs", read_buffer_select, 0);
    check_eq("rst_pixval", mcu_if.out_pixval, 0);
    check_eq("rst_flags", {mcu_if.out_start_of_mcu, mcu_if.out_end_of_mcu, mcu_if.out_end_of_stripe}, 0);
    check_eq("rst_addr", {read_block_select, read_addr}, 0);
    reset = 1'b0;
    repeat (4) tick();
    check_eq("idle_busy", busy, 0);
    check_eq("idle_rden", rden, 0);

    // ready held high: exact latency, zero bubbles, busy falls right after the last beat
    r0 = reads_total; first_rden = -1; first_valid = -1; valid_cycles = 0;
    frontbuffer_select = 1'b1; exp_buf = 1'b0; beat_idx = 0;
    tick();
    check_eq("t1_busy_rise", busy, 1);
    check_eq("t1_first_rden", rden, 1);
    check_eq("t1_rbs", read_buffer_select, 0);
    check_eq("t1_first_addr", {read_block_select, read_addr}, 0);
    run_beats(beats, 6000);
    check_eq("t1_busy_last", busy, 1);
    tick();
    check_eq("t1_busy_fall", busy, 0);
    check_eq("t1_valid_latency", first_valid - first_rden, 2);
    check_eq("t1_valid_run", last_valid - first_valid + 1, beats);
    check_eq("t1_valid_count", valid_cycles, beats);
    check_eq("t1_reads", reads_total - r0, beats);

    // random backpressure
    ready_rand = 1'b1; r0 = reads_total;
    frontbuffer_select = 1'b0; exp_buf = 1'b1; beat_idx = 0;
    tick();
    check_eq("t2_busy", busy, 1);
    check_eq("t2_rbs", read_buffer_select, 1);
    run_beats(beats, 20000);
    ready_rand = 1'b0;
    repeat (3) tick();
    check_eq("t2_busy_fall", busy, 0);
    check_eq("t2_reads", reads_total - r0, beats);

    // toggle together with the final beat transfer: back-to-back stripes
    r0 = reads_total;
    frontbuffer_select = 1'b1; exp_buf = 1'b0; beat_idx = 0;
    tick();
    check_eq("t3_rbs_first", read_buffer_select, 0);
    chk_busy = 1'b1; end_toggle = 1'b1;
    run_beats(beats - 1, 6000);
    for (int i = 0; i < 10 && end_toggle; i++) tick();
    tick();
    check_eq("t3_rbs_second", read_buffer_select, 1);
    check_eq("t3_restart_rden", rden, 1);
    check_eq("t3_restart_addr", {read_block_select, read_addr}, 0);
    run_beats(beats, 6000);
    chk_busy = 1'b0;
    tick();
    check_eq("t3_busy_fall", busy, 0);
    check_eq("t3_overrun", overrun, 0);
    check_eq("t3_reads", reads_total - r0, 2 * beats);

    // toggle at beat 1000 while busy: overrun, stripe completes, new one dropped
    check_eq("t4_overrun_pre", overrun, 0);
    r0 = reads_total;
    frontbuffer_select = 1'b1; exp_buf = 1'b0; beat_idx = 0; overrun_at = 1000;
    tick();
    run_beats(beats, 6000);
    repeat (10) tick();
    check_eq("t4_overrun_sticky", overrun, 1);
    check_eq("t4_busy", busy, 0);
    check_eq("t4_reads", reads_total - r0, beats);
    check_eq("t4_rbs", read_buffer_select, 0);

    // reset clears overrun; a select change during reset is not a start
    reset = 1'b1; reads_total = 0; xfers_total = 0; beat_idx = 0;
    tick();
    frontbuffer_select = 1'b1;
    repeat (2) tick();
    check_eq("rst2_overrun", overrun, 0);
    check_eq("rst2_rbs", read_buffer_select, 0);
    reset = 1'b0;
    repeat (4) tick();
    check_eq("rst2_no_start", busy, 0);

    // reset mid-stripe at beat 300, then restart from MCU 0
    ready_rand = 1'b1;
    frontbuffer_select = 1'b0; exp_buf = 1'b1; beat_idx = 0;
    tick();
    run_beats(300, 6000);
    reset = 1'b1; reads_total = 0; xfers_total = 0; beat_idx = 0; v0 = valid_cycles;
    tick();
    check_eq("t5_abort_valid", mcu_if.out_valid, 0);
    check_eq("t5_abort_rden", rden, 0);
    check_eq("t5_abort_busy", busy, 0);
    reset = 1'b0;
    repeat (20) tick();
    check_eq("t5_no_beats", valid_cycles - v0, 0);
    check_eq("t5_idle_busy", busy, 0);
    frontbuffer_select = 1'b1; exp_buf = 1'b0; beat_idx = 0;
    tick();
    check_eq("t5_restart_rden", rden, 1);
    check_eq("t5_restart_addr", {read_block_select, read_addr}, 0);
    run_beats(beats, 20000);
    ready_rand = 1'b0;
    repeat (3) tick();
    check_eq("t5_busy_fall", busy, 0);
    check_eq("t5_reads", reads_total, beats);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/hm01b0_mcu_reader.md
# hm01b0_mcu_reader

Reads completed 8-row stripes back out of the HM01B0 ingester's double-buffered EBR bank and emits them as a stream of 8x8 MCUs for the downstream JPEG stage. It sits between the EBR bank (read port) and the DCT input. A stripe becomes readable whenever the ingester's `frontbuffer_select` toggles. Samples leave in MCU order (MCU 0..39), row-major within each MCU, over a valid/ready handshake with full backpressure.

## Interface
- `width_pix`, 320: image width in pixels; MCUs per stripe = `width_pix/8` = 40.
- `num_ebr`, 5: EBRs per buffer half.
- `ebr_size`, 512: bytes per EBR.

- `clock`  in  1  system clock; everything is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `frontbuffer_select`  in  1  ingester's current write half; any change means the other half holds a finished stripe.
- `read_buffer_select`  out  1  buffer half being read.
- `read_block_select`  out  clog2(num_ebr)  EBR index.
- `read_addr`  out  clog2(ebr_size)  EBR byte address.
- `rden`  out  1  read strobe; `read_data` is valid exactly 1 cycle later.
- `read_data`  in  8  EBR read data.
- `out_pixval`  out  8  sample.
- `out_valid`  out  1  sample valid.
- `out_ready`  in  1  consumer accepts; a beat transfers when valid&&ready.
- `out_start_of_mcu`  out  1  qualifies beat 0 of each MCU.
- `out_end_of_mcu`  out  1  qualifies beat 63 of each MCU.
- `out_end_of_stripe`  out  1  qualifies beat 2559.
- `busy`  out  1  a stripe is in progress.
- `overrun`  out  1  sticky error flag.

## Operation
- Toggle detection: a register holds the last sampled `frontbuffer_select`. A mismatch is a toggle event.
- Reset: all outputs are 0, including `overrun` and `read_buffer_select`. Internal counters and the skid buffer are cleared. The held copy loads the current `frontbuffer_select`, so reset never produces a spurious start.
- States:
  - IDLE: on a toggle, latch `read_buffer_select` = new `frontbuffer_select` inverted, clear counters, and go to READ.
  - READ: issue reads. After read 2559 is issued, go to DRAIN.
  - DRAIN: when the last beat transfers, go to IDLE.
- `busy` is high in READ and DRAIN.
- Read order uses ripple counters: px 0..7, then py 0..7, then mcu 0..39.
  - `read_block_select` = mcu mod num_ebr.
  - `read_addr` = {mcu div num_ebr (3b), py, px}.
  - Example: MCU 5 reads block 0, addr 64..127. MCU 39 reads block 4, addr 448..511.
- Flow control uses a 2-entry skid buffer.
  - `rden` may assert only if (buffered + in-flight − popping this cycle) < 2.
  - This sustains 1 beat/cycle with `out_ready` held high, and never loses data under stall.
  - While valid && !ready, `out_pixval` and all flags are held stable.
- Flags travel with their sample through the buffer.
- Toggle while busy:
  - Set `overrun` (sticky until reset).
  - The current stripe continues unchanged.
  - The new stripe is dropped, not queued.
  - The held copy is updated, so that toggle is consumed.
- A toggle sampled in the same cycle as the final beat transfer is a normal start, not an overrun. The design goes straight to READ without passing through IDLE.
- Reset mid-stripe aborts immediately. Buffered and in-flight data are discarded.

## Timing
- Toggle sampled at edge E: `busy` = 1 and first `rden` in the cycle after E.
- First `out_valid` comes 2 cycles after the first `rden` (1 cycle EBR latency + 1 cycle register stage).
- With `out_ready` held high, `out_valid` stays high for 2560 consecutive cycles.
- `busy` falls the cycle after the beat-2559 transfer.
- `overrun` rises the cycle after the offending toggle is sampled.
- Each stripe takes a minimum of 2563 cycles from toggle to idle. The ingester delivers a stripe in ≥2560 pixclk periods of several system clocks each, so `overrun` signals a consumer stall, never normal operation.

## Test plan
- Reset, then toggle 0→1 with ready=1 and a 1-cycle-latency EBR model preloaded so data = f(buf, block, addr):
  - `read_buffer_select` = 0.
  - Beats 0..63 come from block 0 addr 0..63; beats 64..127 from block 1 addr 0..63; the last MCU from block 4 addr 448..511.
  - `out_start_of_mcu` on beats 0, 64, …, 2496; `out_end_of_stripe` only on beat 2559; `busy` falls 1 cycle after.
- Random `out_ready` (50%):
  - Same 2560-beat sequence, no duplicates or drops.
  - Outputs stable during stall.
  - Never more than 2 reads outstanding plus buffered.
- Second toggle at beat 1000:
  - `overrun` = 1 next cycle and stays 1.
  - The first stripe completes all 2560 beats.
  - No second stripe starts.
- Toggle sampled in the same cycle as the beat-2559 transfer:
  - A new stripe starts with `read_buffer_select` = 1.
  - `overrun` stays 0.
  - `busy` never drops.
- `reset` at beat 300:
  - Next cycle `out_valid` = `rden` = `busy` = 0.
  - No further beats until a new toggle.
  - A new toggle restarts at MCU 0 addr 0.
- Ready held high: `out_valid` is continuously high from first `rden` + 2 through first `rden` + 2561; zero bubbles.
